// File: rtl/xmodem_pkg.sv
// Shared XMODEM definitions: control byte values, error codes and receive parser states.
package xmodem_pkg;

    localparam logic [7:0] SOH = 8'h01;
    localparam logic [7:0] STX = 8'h02;
    localparam logic [7:0] EOT = 8'h04;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;
    localparam logic [7:0] CAN = 8'h18;

    localparam int unsigned LEN_1K = 32'd1024;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BLK     = 2'd1,
        ERR_CRC     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_BLK  = 3'd1,
        ST_BLKN = 3'd2,
        ST_DATA = 3'd3,
        ST_CRCH = 3'd4,
        ST_CRCL = 3'd5
    } state_e;

endpackage

// File: rtl/xmodem_timeout_cnt.sv
// Inter-byte timeout counter shared by the XMODEM receive and transmit sides.
// Clears on i_clr, otherwise counts and saturates at LIMIT-1; o_expire marks the step that reaches it.
module xmodem_timeout_cnt #(
    parameter int unsigned LIMIT = 32'd100000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_expire
);
    localparam logic [31:0] LAST = 32'(LIMIT - 32'd1);

    logic [31:0] r_cnt;
    logic [31:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + 32'd1;
    assign o_expire  = !i_clr && (w_cnt_inc == LAST);

    // Counter: cleared on activity, holds once the limit has been reached
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= 32'd0;
        end else if (r_cnt != LAST) begin
            r_cnt <= w_cnt_inc;
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/xmodem_frame_rx.sv
// Receive-side XMODEM-CRC frame parser driving an external CRC16-XMODEM engine.
// Defining XMODEM_1K_EN additionally accepts STX frames carrying 1024 payload bytes.
module xmodem_frame_rx
    import xmodem_pkg::*;
#(
    parameter int unsigned PAYLOAD_LEN = 32'd128,
    parameter int unsigned TIMEOUT_CYC = 32'd100000000
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        IN_VALID_I,
    input  logic [7:0]  IN_DATA_I,
    output logic        CRC_RST_O,
    output logic        CRC_VALID_O,
    output logic [7:0]  CRC_DATA_O,
    input  logic [15:0] CRC_I,
    output logic        PLD_VALID_O,
    output logic [7:0]  PLD_DATA_O,
    output logic [9:0]  PLD_IDX_O,
    output logic [7:0]  BLK_NUM_O,
    output logic        FRAME_OK_O,
    output logic        FRAME_ERR_O,
    output logic [1:0]  ERR_CODE_O,
    output logic        EOT_O,
    output logic        CAN_O
);
    localparam logic [9:0] LAST_IDX = 10'(PAYLOAD_LEN - 32'd1);

    state_e     r_state, w_next_state;
    err_code_e  r_err_code, w_err_code;
    logic [7:0] r_blk_num, r_crc_hi, r_pld_data;
    logic [9:0] r_idx, r_pld_idx, w_last_idx;
    logic       r_pld_valid, r_frame_ok, r_frame_err, r_eot, r_can;
    logic       w_frame_ok, w_frame_err, w_eot, w_can, w_start;
    logic       w_crc_rst, w_crc_valid, w_data_byte, w_to_expire;

`ifdef XMODEM_1K_EN
    logic r_is_1k, w_start_1k;
    assign w_last_idx = r_is_1k ? 10'(LEN_1K - 32'd1) : LAST_IDX;
`else
    assign w_last_idx = LAST_IDX;
`endif

    assign w_data_byte = IN_VALID_I && (r_state == ST_DATA);

    xmodem_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_timeout (
        .i_clk    (CLK_I),
        .i_rst    (RST_I),
        .i_clr    (IN_VALID_I || (r_state == ST_IDLE)),
        .o_expire (w_to_expire)
    );

    // Next-state decode; a received byte always takes priority over a timeout in the same cycle
    always_comb begin
        w_next_state = r_state;
        w_err_code   = r_err_code;
        w_frame_ok   = 1'b0;
        w_frame_err  = 1'b0;
        w_eot        = 1'b0;
        w_can        = 1'b0;
        w_start      = 1'b0;
        w_crc_rst    = 1'b0;
        w_crc_valid  = 1'b0;
`ifdef XMODEM_1K_EN
        w_start_1k   = 1'b0;
`endif
        if (IN_VALID_I) begin
            case (r_state)
                ST_IDLE: begin
                    if (IN_DATA_I == SOH) begin
                        w_next_state = ST_BLK;
                        w_crc_rst    = 1'b1;
                        w_start      = 1'b1;
                    end
`ifdef XMODEM_1K_EN
                    else if (IN_DATA_I == STX) begin
                        w_next_state = ST_BLK;
                        w_crc_rst    = 1'b1;
                        w_start      = 1'b1;
                        w_start_1k   = 1'b1;
                    end
`endif
                    else if (IN_DATA_I == EOT) begin
                        w_eot = 1'b1;
                    end else if (IN_DATA_I == CAN) begin
                        w_can = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_BLK:  w_next_state = ST_BLKN;
                ST_BLKN: begin
                    if ((r_blk_num ^ IN_DATA_I) != 8'hFF) begin
                        w_frame_err  = 1'b1;
                        w_err_code   = ERR_BLK;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_DATA;
                    end
                end
                ST_DATA: begin
                    w_crc_valid = 1'b1;
                    if (r_idx == w_last_idx) begin
                        w_next_state = ST_CRCH;
                    end else begin
                        w_next_state = ST_DATA;
                    end
                end
                ST_CRCH: w_next_state = ST_CRCL;
                ST_CRCL: begin
                    if ({r_crc_hi, IN_DATA_I} == CRC_I) begin
                        w_frame_ok  = 1'b1;
                    end else begin
                        w_frame_err = 1'b1;
                        w_err_code  = ERR_CRC;
                    end
                    w_next_state = ST_IDLE;
                end
                default: w_next_state = ST_IDLE;
            endcase
        end else if (w_to_expire && (r_state != ST_IDLE)) begin
            w_frame_err  = 1'b1;
            w_err_code   = ERR_TIMEOUT;
            w_next_state = ST_IDLE;
        end else begin
            w_next_state = r_state;
        end
    end

    // Frame registers, payload forwarding and registered verdict pulses
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state     <= ST_IDLE;
            r_err_code  <= ERR_NONE;
            r_blk_num   <= 8'h00;
            r_crc_hi    <= 8'h00;
            r_pld_data  <= 8'h00;
            r_idx       <= 10'd0;
            r_pld_idx   <= 10'd0;
            r_pld_valid <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_eot       <= 1'b0;
            r_can       <= 1'b0;
`ifdef XMODEM_1K_EN
            r_is_1k     <= 1'b0;
`endif
        end else begin
            r_state     <= w_next_state;
            r_err_code  <= w_err_code;
            r_frame_ok  <= w_frame_ok;
            r_frame_err <= w_frame_err;
            r_eot       <= w_eot;
            r_can       <= w_can;
            r_pld_valid <= w_data_byte;
            if (w_start) r_idx <= 10'd0;
            if (w_data_byte) begin
                r_pld_data <= IN_DATA_I;
                r_pld_idx  <= r_idx;
                r_idx      <= r_idx + 10'd1;
            end
            if (IN_VALID_I && (r_state == ST_BLK))  r_blk_num <= IN_DATA_I;
            if (IN_VALID_I && (r_state == ST_CRCH)) r_crc_hi  <= IN_DATA_I;
`ifdef XMODEM_1K_EN
            if (w_start) r_is_1k <= w_start_1k;
`endif
        end
    end

    assign CRC_RST_O   = w_crc_rst;
    assign CRC_VALID_O = w_crc_valid;
    assign CRC_DATA_O  = IN_DATA_I;
    assign PLD_VALID_O = r_pld_valid;
    assign PLD_DATA_O  = r_pld_data;
    assign PLD_IDX_O   = r_pld_idx;
    assign BLK_NUM_O   = r_blk_num;
    assign FRAME_OK_O  = r_frame_ok;
    assign FRAME_ERR_O = r_frame_err;
    assign ERR_CODE_O  = r_err_code;
    assign EOT_O       = r_eot;
    assign CAN_O       = r_can;

endmodule
